// File: rtl/oci_dct_pack_ctrl.sv
// DCT trace packer: folds FRAG_W-bit fragments into 30-bit words and owns end-of-test flush.
// Optional idle-timeout flush of partial words is enabled by defining OCI_DCT_IDLE_FLUSH_EN.
module oci_dct_pack_ctrl #(
   parameter int FRAG_W         = 10,
   parameter int FRAGS_PER_WORD = 3,
   parameter int IDLE_FLUSH     = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frag_valid,
   input  logic [FRAG_W-1:0] frag_data,
   output logic              frag_ready,
   output logic [29:0]       dct_buffer,
   output logic [3:0]        dct_count,
   output logic              dct_valid,
   input  logic              dct_ready,
   input  logic              test_ending,
   output logic              test_has_ended
);

   localparam int         WORD_W   = 30;
   localparam logic [3:0] FULL_CNT = 4'(FRAGS_PER_WORD);

   if (FRAG_W * FRAGS_PER_WORD != WORD_W || FRAGS_PER_WORD < 1 ||
       FRAGS_PER_WORD > 15 || IDLE_FLUSH < 1) begin : g_param_check
      $error("oci_dct_pack_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      PACK = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic        pack_rdy;
   logic        flush_q;
   logic        accept;
   logic        flush_now;
   logic        idle_hit;
   logic [3:0]  cnt_next;
   logic [29:0] buf_next;

   function automatic logic [29:0] place_frag(input logic [29:0]       w,
                                              input logic [3:0]        slot,
                                              input logic [FRAG_W-1:0] d);
      logic [29:0] r;
      r = w;
      for (int i = 0; i < FRAGS_PER_WORD; i++) begin
         if (slot == 4'(i)) r[i*FRAG_W +: FRAG_W] = d;
      end
      return r;
   endfunction

   // pack_rdy tracks the PACK state; reset masks it so nothing is accepted while held
   assign frag_ready = pack_rdy & ~reset;
   assign accept     = frag_valid & frag_ready;
   assign flush_now  = flush_q | test_ending;
   assign cnt_next   = accept ? dct_count + 4'd1 : dct_count;
   assign buf_next   = accept ? place_frag(dct_buffer, dct_count, frag_data) : dct_buffer;

`ifdef OCI_DCT_IDLE_FLUSH_EN
   localparam int IDLE_W = (IDLE_FLUSH < 2) ? 1 : $clog2(IDLE_FLUSH + 1);

   logic [IDLE_W-1:0] idle_cnt;

   // Fires on the cycle the counter would reach IDLE_FLUSH
   assign idle_hit = (state == PACK) && !accept && (dct_count != 4'd0) &&
                     (idle_cnt == IDLE_W'(IDLE_FLUSH - 1));

   always_ff @(posedge clk) begin
      if (reset || state != PACK || accept || dct_count == 4'd0) begin
         idle_cnt <= '0;
      end else if (!idle_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign idle_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= PACK;
         pack_rdy       <= 1'b1;
         flush_q        <= 1'b0;
         dct_valid      <= 1'b0;
         test_has_ended <= 1'b0;
         dct_buffer     <= '0;
         dct_count      <= '0;
      end else begin
         case (state)
            PACK: begin
               if (test_ending) flush_q <= 1'b1;
               dct_buffer <= buf_next;
               dct_count  <= cnt_next;
               // The fragment lands first; flush then sees the updated count
               if (cnt_next == FULL_CNT ||
                   (cnt_next != 4'd0 && (flush_now || idle_hit))) begin
                  state     <= EMIT;
                  pack_rdy  <= 1'b0;
                  dct_valid <= 1'b1;
               end else if (flush_now) begin
                  state          <= DONE;
                  pack_rdy       <= 1'b0;
                  test_has_ended <= 1'b1;
               end
            end
            EMIT: begin
               if (test_ending) flush_q <= 1'b1;
               if (dct_ready) begin
                  dct_buffer <= '0;
                  dct_count  <= '0;
                  dct_valid  <= 1'b0;
                  if (flush_now) begin
                     state          <= DONE;
                     test_has_ended <= 1'b1;
                  end else begin
                     state    <= PACK;
                     pack_rdy <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state     <= PACK;
               pack_rdy  <= 1'b1;
               dct_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oci_dct_pack_ctrl.sv
// Bench for oci_dct_pack_ctrl: directed vector table, idle/throughput sequences,
// and a randomized run scored against a fragment-queue model.
module tb_oci_dct_pack_ctrl;

   localparam int FRAG_W     = 10;
   localparam int FPW        = 3;
   localparam int IDLE_FLUSH = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              frag_valid = 1'b0;
   logic [FRAG_W-1:0] frag_data = '0;
   logic              dct_ready = 1'b0;
   logic              test_ending = 1'b0;
   logic              frag_ready;
   logic [29:0]       dct_buffer;
   logic [3:0]        dct_count;
   logic              dct_valid;
   logic              test_has_ended;

   int total = 0;
   int bad   = 0;

   oci_dct_pack_ctrl #(
      .FRAG_W(FRAG_W), .FRAGS_PER_WORD(FPW), .IDLE_FLUSH(IDLE_FLUSH)
   ) dut (
      .clk(clk), .reset(reset), .frag_valid(frag_valid), .frag_data(frag_data),
      .frag_ready(frag_ready), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .dct_ready(dct_ready), .test_ending(test_ending),
      .test_has_ended(test_has_ended)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic              rst, fv;
      logic [FRAG_W-1:0] fd;
      logic              dr, te;
      logic              fr, dv;
      logic [29:0]       wbuf;
      logic [3:0]        cnt;
      logic              th;
   } vec_t;

   vec_t              vecs[$];
   logic [FRAG_W-1:0] q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic rst, input logic fv, input logic [FRAG_W-1:0] fd,
                               input logic dr, input logic te, input logic fr, input logic dv,
                               input logic [29:0] wbuf, input logic [3:0] cnt, input logic th);
      vec_t v;
      v.rst = rst; v.fv = fv; v.fd = fd; v.dr = dr; v.te = te;
      v.fr = fr; v.dv = dv; v.wbuf = wbuf; v.cnt = cnt; v.th = th;
      vecs.push_back(v);
   endfunction

   // Expected word: first n queued fragments, fragment i at bit FRAG_W*i
   function automatic logic [29:0] pack_front(input int n);
      logic [29:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w = w | (30'(q[i]) << (FRAG_W * i));
      return w;
   endfunction

   initial begin
      vec_t v;
      int   first;
      int   nwords;
      int   streak;
      logic hold;
      logic [29:0] hold_buf;
      logic [3:0]  hold_cnt;
      logic flushing;
      logic ended;
      int   n;

      //  rst fv  fd      dr te | fr dv  buffer          cnt th
      add(1, 0, 10'h000, 0, 0,   0, 0, 30'h0,          0, 0);
      add(0, 1, 10'h001, 1, 0,   1, 0, 30'h0,          0, 0);
      add(0, 1, 10'h002, 1, 0,   1, 0, 30'h001,        1, 0);
      add(0, 1, 10'h003, 1, 0,   1, 0, 30'h00801,      2, 0);
      add(0, 1, 10'h155, 1, 0,   0, 1, 30'h00300801,   3, 0);
      add(0, 1, 10'h155, 0, 0,   1, 0, 30'h0,          0, 0);
      add(0, 1, 10'h0AA, 0, 0,   1, 0, 30'h155,        1, 0);
      add(0, 1, 10'h011, 0, 0,   1, 0, 30'h2A955,      2, 0);
      for (int i = 0; i < 5; i++)
         add(0, 1, 10'h3FF, 0, 0, 0, 1, 30'h112A955,   3, 0);
      add(0, 1, 10'h3FF, 1, 0,   0, 1, 30'h112A955,    3, 0);
      add(0, 1, 10'h3FF, 1, 0,   1, 0, 30'h0,          0, 0);
      add(0, 0, 10'h000, 1, 1,   1, 0, 30'h3FF,        1, 0);
      add(0, 1, 10'h005, 0, 0,   0, 1, 30'h3FF,        1, 0);
      add(0, 1, 10'h005, 1, 0,   0, 1, 30'h3FF,        1, 0);
      add(0, 1, 10'h005, 1, 0,   0, 0, 30'h0,          0, 1);
      add(0, 1, 10'h005, 1, 0,   0, 0, 30'h0,          0, 1);
      add(1, 0, 10'h000, 1, 0,   0, 0, 30'h0,          0, 1);
      add(0, 0, 10'h000, 1, 1,   1, 0, 30'h0,          0, 0);
      add(0, 1, 10'h005, 1, 0,   0, 0, 30'h0,          0, 1);
      add(1, 0, 10'h000, 1, 0,   0, 0, 30'h0,          0, 1);
      add(0, 1, 10'h007, 1, 0,   1, 0, 30'h0,          0, 0);
      add(0, 1, 10'h008, 1, 0,   1, 0, 30'h007,        1, 0);
      add(0, 1, 10'h009, 1, 1,   1, 0, 30'h2007,       2, 0);
      add(0, 0, 10'h000, 1, 0,   0, 1, 30'h902007,     3, 0);
      add(0, 0, 10'h000, 1, 0,   0, 0, 30'h0,          0, 1);
      add(1, 0, 10'h000, 0, 0,   0, 0, 30'h0,          0, 1);
      add(0, 1, 10'h010, 0, 0,   1, 0, 30'h0,          0, 0);
      add(0, 1, 10'h020, 0, 0,   1, 0, 30'h010,        1, 0);
      add(1, 0, 10'h000, 0, 0,   0, 0, 30'h8010,       2, 0);
      add(0, 1, 10'h021, 0, 0,   1, 0, 30'h0,          0, 0);
      add(0, 1, 10'h022, 0, 0,   1, 0, 30'h021,        1, 0);
      add(0, 1, 10'h023, 1, 0,   1, 0, 30'h8821,       2, 0);
      add(0, 0, 10'h000, 1, 0,   0, 1, 30'h2308821,    3, 0);
      add(0, 0, 10'h000, 1, 0,   1, 0, 30'h0,          0, 0);

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         reset = v.rst; frag_valid = v.fv; frag_data = v.fd;
         dct_ready = v.dr; test_ending = v.te;
         #1;
         chk($sformatf("v%0d_frag_ready", i), 32'(frag_ready), 32'(v.fr));
         chk($sformatf("v%0d_dct_valid", i), 32'(dct_valid), 32'(v.dv));
         chk($sformatf("v%0d_dct_buffer", i), 32'(dct_buffer), 32'(v.wbuf));
         chk($sformatf("v%0d_dct_count", i), 32'(dct_count), 32'(v.cnt));
         chk($sformatf("v%0d_test_has_ended", i), 32'(test_has_ended), 32'(v.th));
         tick();
      end

      // Idle sequence: two fragments, then silence
      reset = 1'b0; test_ending = 1'b0; dct_ready = 1'b1;
      frag_valid = 1'b1; frag_data = 10'h031;
      #1; chk("idle_acc0", 32'(frag_ready), 32'd1);
      tick();
      frag_data = 10'h032;
      #1; chk("idle_acc1", 32'(frag_ready), 32'd1);
      tick();
      frag_valid = 1'b0;
      first = 0;
      for (int k = 1; k <= 100; k++) begin
         #1;
         if (dct_valid) begin
            first = k;
            break;
         end
         tick();
      end
`ifdef OCI_DCT_IDLE_FLUSH_EN
      chk("idle_delay", 32'(first), 32'(IDLE_FLUSH + 1));
      chk("idle_count", 32'(dct_count), 32'd2);
      chk("idle_buffer", 32'(dct_buffer), 32'h0000C831);
      tick();
      chk("idle_resume", 32'(frag_ready), 32'd1);
      chk("idle_not_ended", 32'(test_has_ended), 32'd0);
`else
      chk("idle_no_word", 32'(first), 32'd0);
      chk("idle_held_count", 32'(dct_count), 32'd2);
`endif

      // Throughput with a continuous source and dct_ready tied high
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      frag_valid = 1'b1; dct_ready = 1'b1;
      nwords = 0;
      for (int k = 0; k < 40; k++) begin
         frag_data = 10'($urandom);
         #1;
         if (dct_valid) nwords++;
         tick();
      end
      chk("throughput_words", 32'(nwords), 32'd10);

      // Randomized run scored against the accepted-fragment queue
      frag_valid = 1'b0;
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      q.delete();
      streak = 0; hold = 1'b0; hold_buf = '0; hold_cnt = '0;
      for (int c = 0; c < 1500; c++) begin
         frag_valid = (streak >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
         frag_data  = 10'($urandom);
         dct_ready  = ($urandom_range(0, 2) != 0);
         #1;
         if (hold) begin
            chk("rnd_hold_valid", 32'(dct_valid), 32'd1);
            chk("rnd_hold_buffer", 32'(dct_buffer), 32'(hold_buf));
            chk("rnd_hold_count", 32'(dct_count), 32'(hold_cnt));
         end
         chk("rnd_ready_valid_excl", 32'(frag_ready & dct_valid), 32'd0);
         if (frag_valid && frag_ready) q.push_back(frag_data);
         if (dct_valid && dct_ready) begin
            chk("rnd_word_count", 32'(dct_count), 32'(FPW));
            if (q.size() >= FPW) begin
               chk("rnd_word_buffer", 32'(dct_buffer), 32'(pack_front(FPW)));
               for (int j = 0; j < FPW; j++) void'(q.pop_front());
            end else begin
               chk("rnd_word_underflow", 32'(q.size()), 32'(FPW));
               q.delete();
            end
         end
         hold = dct_valid & ~dct_ready;
         hold_buf = dct_buffer; hold_cnt = dct_count;
         streak = frag_valid ? 0 : streak + 1;
         tick();
      end

      // End of test: whatever is queued must come out as one final word
      frag_valid = 1'b0; dct_ready = 1'b1; test_ending = 1'b1;
      flushing = 1'b1; ended = 1'b0;
      for (int c = 0; c < 30 && flushing; c++) begin
         #1;
         if (test_has_ended) begin
            ended = 1'b1;
            flushing = 1'b0;
         end else if (dct_valid) begin
            n = (q.size() > FPW) ? FPW : q.size();
            chk("flush_count", 32'(dct_count), 32'(n));
            chk("flush_buffer", 32'(dct_buffer), 32'(pack_front(n)));
            for (int j = 0; j < n; j++) void'(q.pop_front());
         end
         if (flushing) begin
            tick();
            test_ending = 1'b0;
         end
      end
      test_ending = 1'b0;
      chk("flush_ended", 32'(ended), 32'd1);
      chk("flush_queue_empty", 32'(q.size()), 32'd0);
      chk("flush_valid_low", 32'(dct_valid), 32'd0);
      chk("flush_ready_low", 32'(frag_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
